// File: rtl/mips_pkg.sv
// Types and constants shared by the fetch, control and datapath blocks.
package mips_pkg;

  typedef enum logic {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection for the retiring instruction: sequential, taken beq, or j.
module next_pc_logic
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       instr_target,
  input  logic [ADDR_W-1:0] seOut,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Zero,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_target;

  always_comb begin
    pc4       = pc + WORD_BYTES;
    // The word offset's top two bits fall off the end; modulo 2^32 is intended.
    br_target = pc4 + (seOut << 2);
    next_pc   = pc4;
    if (Jump) begin
      next_pc = {pc4[ADDR_W-1:ADDR_W-4], instr_target, 2'b00};
    end else if (Branch && Zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack memory port and
// hands one registered instruction at a time to the single-cycle datapath.
//
//   state   | meaning
//   S_REQ   | request outstanding at pc, waiting for imem_ack
//   S_VALID | Instructions valid, waiting for the datapath to advance
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Zero,
  input  logic [31:0]       seOut,
  input  logic              advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instructions,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic              req_q;
  logic              fetch_done;
  logic              retire;
  logic [ADDR_W-1:0] next_pc;

  // An ack only counts while the request is actually on the port.
  assign fetch_done = (state == S_REQ) && req_q && imem_ack;
  assign retire     = (state == S_VALID) && advance;

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (fetch_done) state_nxt = S_VALID;
      S_VALID: if (advance)    state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // Request is registered so it can only rise on a clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_REQ;
      req_q        <= 1'b0;
      pc           <= RESET_PC & ~(WORD_BYTES - 1);
      Instructions <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      req_q <= (state_nxt == S_REQ);
      if (fetch_done) Instructions <= imem_rdata;
      if (retire)     pc           <= next_pc;
    end
  end

  next_pc_logic #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc           (pc),
    .instr_target (Instructions[25:0]),
    .seOut        (seOut),
    .Branch       (Branch),
    .Jump         (Jump),
    .Zero         (Zero),
    .next_pc      (next_pc)
  );

  assign imem_req    = req_q;
  assign imem_addr   = pc;
  assign instr_valid = (state == S_VALID);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table of retire controls with
// a queue of expected fetch addresses, plus stall and reset/wrap sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Branch, Jump, Zero, advance;
  logic [31:0] seOut;
  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_rdata, Instructions, pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .Branch       (Branch),
    .Jump         (Jump),
    .Zero         (Zero),
    .seOut        (seOut),
    .advance      (advance),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Instructions (Instructions),
    .instr_valid  (instr_valid),
    .pc           (pc)
  );

  typedef struct {
    logic        b;
    logic        j;
    logic        z;
    logic [31:0] se;
    int          waits;
    logic [31:0] exp_addr;
    string       name;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wait_cfg = 0;
  int          wcnt     = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h2001_07DF;
    else if (a == 32'h1000_0010) return 32'h0800_0100;
    else                         return {a[15:0], ~a[15:0]};
  endfunction

  function automatic vec_t mk(input logic b, input logic j, input logic z,
                              input logic [31:0] se, input int w,
                              input logic [31:0] ea, input string nm);
    vec_t v;
    v.b = b; v.j = j; v.z = z; v.se = se; v.waits = w; v.exp_addr = ea; v.name = nm;
    return v;
  endfunction

  // Memory model: acks after wait_cfg wait cycles, only while the request is up.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 'x;
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b1 && imem_req === 1'b1) begin
        if (wcnt >= wait_cfg) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt       = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 'x;
          wcnt++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 'x;
        wcnt       = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the sample point just after the edge that should have raised imem_req.
  task automatic wait_fetch(input string name, input int waits);
    logic [31:0] a;
    int          n;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty, no expected address", name);
      return;
    end
    a = exp_q.pop_front();
    chk({name, " req"},  {31'b0, imem_req}, 32'd1);
    chk({name, " addr"}, imem_addr, a);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (instr_valid === 1'b1) break;
      chk({name, " req held"},  {31'b0, imem_req}, 32'd1);
      chk({name, " addr held"}, imem_addr, a);
    end
    if (instr_valid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s: instr_valid timeout, got %b expected 1", name, instr_valid);
    end else begin
      chk({name, " latency"}, n, waits + 1);
      chk({name, " instr"},   Instructions, mem_word(a));
      chk({name, " req low"}, {31'b0, imem_req}, 32'd0);
    end
  endtask

  task automatic do_adv(input vec_t v);
    chk({v.name, " valid before"}, {31'b0, instr_valid}, 32'd1);
    wait_cfg = v.waits;
    Branch = v.b; Jump = v.j; Zero = v.z; seOut = v.se; advance = 1'b1;
    exp_q.push_back(v.exp_addr);
    tick();
    advance = 1'b0; Branch = 'x; Jump = 'x; Zero = 'x; seOut = 'x;
    chk({v.name, " valid pulse"}, {31'b0, instr_valid}, 32'd0);
    chk({v.name, " pc"}, pc, v.exp_addr);
    wait_fetch(v.name, v.waits);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 0, 0, 32'h0000_0000, 3, 32'h0000_0004, "seq_4");
    vecs[1]  = mk(0, 0, 0, 32'h0000_0000, 3, 32'h0000_0008, "seq_8");
    vecs[2]  = mk(0, 0, 0, 32'h0000_0000, 3, 32'h0000_000C, "seq_c");
    vecs[3]  = mk(1, 0, 1, 32'h0000_000C, 0, 32'h0000_0040, "br_to_40");
    vecs[4]  = mk(1, 0, 1, 32'hFFFF_FFFE, 0, 32'h0000_003C, "br_back");
    vecs[5]  = mk(0, 0, 0, 32'h0000_0000, 0, 32'h0000_0040, "seq_40");
    vecs[6]  = mk(1, 0, 0, 32'hFFFF_FFFE, 0, 32'h0000_0044, "br_not_taken");
    vecs[7]  = mk(1, 0, 1, 32'h03FF_FFF2, 2, 32'h1000_0010, "br_far");
    vecs[8]  = mk(1, 1, 1, 32'h0000_0010, 0, 32'h1000_0400, "jump_prio");
    vecs[9]  = mk(0, 0, 0, 32'h0000_0000, 1, 32'h1000_0404, "seq_after_j");
    vecs[10] = mk(0, 0, 1, 32'h0000_0100, 0, 32'h1000_0408, "zero_no_br");
    vecs[11] = mk(0, 0, 0, 32'h0000_0000, 0, 32'h1000_040C, "stall_release");
    vecs[12] = mk(1, 0, 1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFC, "br_to_top");
    vecs[13] = mk(0, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, "wrap");

    rst = 1'b0; advance = 1'b0;
    Branch = 'x; Jump = 'x; Zero = 'x; seOut = 'x;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst pc",    pc, 32'h0);
      chk("rst req",   {31'b0, imem_req}, 32'd0);
      chk("rst valid", {31'b0, instr_valid}, 32'd0);
      chk("rst instr", Instructions, 32'h0);
    end
    rst = 1'b1;
    #1;
    chk("release req before edge", {31'b0, imem_req}, 32'd0);
    exp_q.push_back(32'h0);
    tick();
    wait_fetch("first_fetch", 0);

    for (int i = 0; i <= 10; i++) do_adv(vecs[i]);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall instr", Instructions, mem_word(32'h1000_0408));
      chk("stall pc",    pc, 32'h1000_0408);
      chk("stall req",   {31'b0, imem_req}, 32'd0);
      chk("stall valid", {31'b0, instr_valid}, 32'd1);
    end
    do_adv(vecs[11]);

    // Branch to 0x20 with a slow memory, then pull reset while the request waits.
    wait_cfg = 10;
    Branch = 1'b1; Jump = 1'b0; Zero = 1'b1; seOut = 32'hFBFF_FF04; advance = 1'b1;
    tick();
    advance = 1'b0; Branch = 'x; Jump = 'x; Zero = 'x; seOut = 'x;
    chk("midwait req",  {31'b0, imem_req}, 32'd1);
    chk("midwait addr", imem_addr, 32'h0000_0020);
    tick();
    tick();
    chk("midwait addr held", imem_addr, 32'h0000_0020);
    rst = 1'b0;
    #1;
    chk("async rst req",   {31'b0, imem_req}, 32'd0);
    chk("async rst pc",    pc, 32'h0);
    chk("async rst valid", {31'b0, instr_valid}, 32'd0);
    chk("async rst instr", Instructions, 32'h0);
    tick();
    chk("rst held req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    wait_cfg = 0;
    exp_q.push_back(32'h0);
    tick();
    wait_fetch("refetch", 0);

    do_adv(vecs[12]);
    do_adv(vecs[13]);

    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
